alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16; operand/result width in bits, legal range 4..64.
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH); shift-amount width and multiply counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL have port src_1  input  WIDTH  operand A.
REQ-008 SHALL have port src_2  input  WIDTH  operand B / shift amount.
REQ-009 SHALL have port alu_control  input  4  opcode.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have ports zero, carry, negative, overflow  output  1 each  registered flags.
REQ-014 SHALL have port busy  output  1  high while in state MUL.

Function
REQ-015 SHALL accept an operation on a clock edge where in_valid && in_ready; operands and opcode are captured at that edge.
REQ-016 SHALL decode opcodes: 0000 add, 0001 sub, 0010 ~A, 0011 A<<B, 0100 A>>B (logical), 0101 A&B, 0110 A|B, 0111 A+1, 1000 A-1, 1001 A^B, 1010 A>>>B (arithmetic), 1011 mul (low WIDTH bits of A*B unsigned); all other codes execute add.
REQ-017 SHALL, for shifts, use src_2 unsigned; src_2 >= WIDTH yields 0 for 0011/0100 and WIDTH copies of A's MSB for 1010.
REQ-018 SHALL implement FSM states IDLE, MUL, HOLD; reset state IDLE.
REQ-019 SHALL, for non-mul ops, go IDLE/HOLD -> HOLD with out_valid high the cycle after the accept edge (latency 1).
REQ-020 SHALL, for mul, go -> MUL, process one multiplier bit per cycle (shift-add) for exactly WIDTH cycles, then -> HOLD; out_valid high WIDTH+1 cycles after the accept edge.
REQ-021 SHALL drive in_ready = !rst && (state==IDLE || (state==HOLD && out_ready)); in_ready SHALL be 0 in MUL.
REQ-022 SHALL, in HOLD with out_ready high and no new accept, return to IDLE and drop out_valid next cycle.
REQ-023 SHALL, in HOLD with out_ready and in_valid both high, retire current result and accept the new op in the same edge (back-to-back, no bubble).
REQ-024 SHALL hold result and all flags stable while out_valid && !out_ready.
REQ-025 SHALL set zero = (result == 0) and negative = result[WIDTH-1] for every op.
REQ-026 SHALL set carry = unsigned carry-out for add/inc, borrow (A<B unsigned) for sub, borrow (A==0) for dec, 1 when product bits [2*WIDTH-1:WIDTH] nonzero for mul, else 0.
REQ-027 SHALL set overflow = two's-complement signed overflow for add/sub/inc/dec, else 0.
REQ-028 SHALL compute arithmetic modulo 2^WIDTH (wrap-around), e.g. all-ones + 1 = 0.

Reset
REQ-029 SHALL, while rst high at an edge, force state IDLE, out_valid 0, result 0, all flags 0, busy 0, multiply counter 0.
REQ-030 SHALL, on rst in MUL or HOLD, abort the operation; no out_valid pulse for it after reset release.
REQ-031 SHALL ignore in_valid during any cycle rst is high.

Verification (WIDTH=16)
REQ-032 SHALL cover: add 0xFFFF+0x0001 -> next cycle out_valid=1, result=0x0000, zero=1, carry=1, overflow=0.
REQ-033 SHALL cover: add 0x7FFF+0x0001 -> result=0x8000, negative=1, overflow=1, carry=0; sub 0x0003-0x0005 -> result=0xFFFE, carry=1.
REQ-034 SHALL cover: mul 0x0123*0x0010 -> busy=1 and in_ready=0 for 16 cycles, out_valid at accept+17, result=0x1230, carry=0; mul 0x8000*0x0002 -> result=0x0000, zero=1, carry=1.
REQ-035 SHALL cover: sra 0x8000 by 20 -> result=0xFFFF; shl 0x0001 by 16 -> result=0x0000, zero=1.
REQ-036 SHALL cover: out_ready held low 5 cycles after out_valid -> result/flags unchanged, in_ready=0; then out_ready and in_valid high together -> new op accepted same edge, next result next cycle.
REQ-037 SHALL cover: rst asserted 5 cycles into a mul -> next cycle out_valid=0, busy=0, result=0, in_ready=1 after release, no stale result emitted.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, shift-add multiply
// taking WIDTH cycles, and a valid/ready handshake on both sides.
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_1,
   input  logic [WIDTH-1:0] src_2,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH;
   localparam logic [WIDTH-1:0] ONE_V    = 1;
   localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_NOT = 4'b0010, OP_SHL = 4'b0011,
      OP_SHR = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110, OP_INC = 4'b0111,
      OP_DEC = 4'b1000, OP_XOR = 4'b1001, OP_SRA = 4'b1010, OP_MUL = 4'b1011
   } op_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW-1:0]     cnt_q, cnt_d;

   logic               accept;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;
   logic [WIDTH:0]     sum_ext;
   logic [SHW-1:0]     shamt;
   logic               shamt_big;

   assign in_ready  = !rst && (state_q == IDLE || (state_q == HOLD && out_ready));
   assign accept    = in_valid && in_ready;
   assign shamt     = src_2[SHW-1:0];
   assign shamt_big = (src_2 >= WIDTH_V);

   // Single-cycle datapath: result and carry/overflow for every non-mul opcode.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      sum_ext   = '0;
      case (alu_control)
         OP_SUB: begin
            alu_res   = src_1 - src_2;
            alu_carry = (src_1 < src_2);
            alu_ovf   = (src_1[WIDTH-1] != src_2[WIDTH-1]) && (alu_res[WIDTH-1] != src_1[WIDTH-1]);
         end
         OP_NOT: alu_res = ~src_1;
         OP_SHL: alu_res = shamt_big ? '0 : (src_1 << shamt);
         OP_SHR: alu_res = shamt_big ? '0 : (src_1 >> shamt);
         OP_AND: alu_res = src_1 & src_2;
         OP_OR:  alu_res = src_1 | src_2;
         OP_XOR: alu_res = src_1 ^ src_2;
         OP_SRA: alu_res = shamt_big ? {WIDTH{src_1[WIDTH-1]}}
                                     : WIDTH'($signed(src_1) >>> shamt);
         OP_INC: begin
            sum_ext   = {1'b0, src_1} + {1'b0, ONE_V};
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = !src_1[WIDTH-1] && alu_res[WIDTH-1];
         end
         OP_DEC: begin
            alu_res   = src_1 - ONE_V;
            alu_carry = (src_1 == '0);
            alu_ovf   = src_1[WIDTH-1] && !alu_res[WIDTH-1];
         end
         default: begin
            // add, and every unassigned opcode
            sum_ext   = {1'b0, src_1} + {1'b0, src_2};
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (src_1[WIDTH-1] == src_2[WIDTH-1]) && (alu_res[WIDTH-1] != src_1[WIDTH-1]);
         end
      endcase
   end

   // Next-state logic: FSM, multiply iteration and result/flag capture.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;

      case (state_q)
         MUL: begin
            // one multiplier bit per cycle, LSB first
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d  = HOLD;
               cnt_d    = '0;
               result_d = acc_d[WIDTH-1:0];
               zero_d   = (acc_d[WIDTH-1:0] == '0);
               neg_d    = acc_d[WIDTH-1];
               carry_d  = |acc_d[2*WIDTH-1:WIDTH];
               ovf_d    = 1'b0;
            end
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: ;
      endcase

      // A new accept (from IDLE, or back-to-back from HOLD) overrides the above.
      if (accept) begin
         if (alu_control == OP_MUL) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, src_1};
            mplier_d = src_2;
            cnt_d    = '0;
         end else begin
            state_d  = HOLD;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, so an aborted multiply leaves no residue.
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q == MUL);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;

   localparam int WIDTH = 16;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  src_1;
   logic [WIDTH-1:0]  src_2;
   logic [3:0]        alu_control;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic              zero;
   logic              carry;
   logic              negative;
   logic              overflow;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   alu_mc #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src_1(src_1), .src_2(src_2), .alu_control(alu_control),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against the expected one.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {out_valid, result, zero, carry, negative, overflow}
   function automatic logic [63:0] obs();
      return 64'({out_valid, result, zero, carry, negative, overflow});
   endfunction

   function automatic logic [63:0] want(input logic [15:0] r, input logic z, input logic c,
                                        input logic n, input logic v);
      return 64'({1'b1, r, z, c, n, v});
   endfunction

   // Present one op with in_valid for exactly one edge.
   task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
      alu_control = op;
      src_1       = a;
      src_2       = b;
      in_valid    = 1'b1;
      #1;
      check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Single-cycle op: result one edge after accept, then retire to IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r, input logic z,
                         input logic c, input logic n, input logic v);
      out_ready = 1'b1;
      issue(tag, op, a, b);
      check(tag, obs(), want(r, z, c, n, v));
      step();
      check({tag, "_idle"}, 64'(out_valid), 64'd0);
   endtask

   // Multiply: busy and not ready for WIDTH cycles, then the result.
   task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic z, input logic c, input logic n);
      out_ready = 1'b1;
      issue(tag, 4'b1011, a, b);
      for (int i = 0; i < WIDTH; i++) begin
         check({tag, "_busy"}, 64'({busy, in_ready, out_valid}), 64'b100);
         step();
      end
      check(tag, obs(), want(r, z, c, n, 1'b0));
      check({tag, "_nbusy"}, 64'(busy), 64'd0);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      src_1       = '0;
      src_2       = '0;
      alu_control = '0;
      step();
      step();
      check("reset_outs", 64'({out_valid, busy, in_ready, result, zero, carry, negative, overflow}), 64'd0);
      rst = 1'b0;
      #1;
      check("reset_rdy", 64'(in_ready), 64'd1);

      run_op("add_wrap",  4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0);
      run_op("add_ovf",   4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1);
      run_op("sub_brw",   4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0);
      run_op("sub_ovf",   4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
      run_op("not",       4'b0010, 16'h00FF, 16'h1234, 16'hFF00, 0, 0, 1, 0);
      run_op("shl_4",     4'b0011, 16'h0003, 16'h0004, 16'h0030, 0, 0, 0, 0);
      run_op("shl_16",    4'b0011, 16'h0001, 16'h0010, 16'h0000, 1, 0, 0, 0);
      run_op("shr_15",    4'b0100, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0);
      run_op("shr_16",    4'b0100, 16'h8000, 16'h0010, 16'h0000, 1, 0, 0, 0);
      run_op("and",       4'b0101, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0);
      run_op("or",        4'b0110, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 1, 0);
      run_op("inc_wrap",  4'b0111, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0);
      run_op("inc_ovf",   4'b0111, 16'h7FFF, 16'h0000, 16'h8000, 0, 0, 1, 1);
      run_op("dec_zero",  4'b1000, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 1, 0);
      run_op("dec_ovf",   4'b1000, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 0, 1);
      run_op("xor",       4'b1001, 16'hA5A5, 16'hFFFF, 16'h5A5A, 0, 0, 0, 0);
      run_op("sra_20",    4'b1010, 16'h8000, 16'h0014, 16'hFFFF, 0, 0, 1, 0);
      run_op("sra_4",     4'b1010, 16'h8000, 16'h0004, 16'hF800, 0, 0, 1, 0);
      run_op("sra_pos",   4'b1010, 16'h4000, 16'h0002, 16'h1000, 0, 0, 0, 0);
      run_op("op_1111",   4'b1111, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0);

      run_mul("mul_a",  16'h0123, 16'h0010, 16'h1230, 0, 0, 0);
      run_mul("mul_hi", 16'h8000, 16'h0002, 16'h0000, 1, 1, 0);
      run_mul("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0001, 0, 1, 0);

      // Backpressure: result held for 5 cycles, then back-to-back accept.
      out_ready = 1'b0;
      issue("bp", 4'b0000, 16'h1234, 16'h1111);
      check("bp_first", obs(), want(16'h2345, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold", obs(), want(16'h2345, 0, 0, 0, 0));
         check("bp_nrdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      issue("b2b", 4'b1001, 16'h00FF, 16'h0F0F);
      check("b2b_res", obs(), want(16'h0FF0, 0, 0, 0, 0));
      step();
      check("b2b_idle", 64'(out_valid), 64'd0);

      // Reset five cycles into a multiply, with in_valid held during reset.
      issue("rst_mul", 4'b1011, 16'h0123, 16'h0010);
      for (int i = 0; i < 4; i++) step();
      check("rst_pre", 64'(busy), 64'd1);
      step();
      rst         = 1'b1;
      in_valid    = 1'b1;
      alu_control = 4'b0000;
      src_1       = 16'h0001;
      src_2       = 16'h0001;
      #1;
      check("rst_nrdy", 64'(in_ready), 64'd0);
      step();
      check("rst_outs", 64'({out_valid, busy, result, zero, carry, negative, overflow}), 64'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check("rst_rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < WIDTH + 4; i++) begin
         step();
         check("rst_nostale", 64'({out_valid, busy}), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
